// File: rtl/pc_branch_unit.sv
// Program counter and branch-resolution stage: next-PC select, carry register,
// start/done handshake, taken-branch counter and branch-target LUT.
module pc_branch_unit #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 StallIn,
    input  logic                 BranchEn,
    input  logic                 BR_FLAG,
    input  logic [LUT_IDX_W-1:0] LutIdx,
    input  logic                 Halt,
    input  logic                 ScIn,
    input  logic                 ScWrEn,
    input  logic                 LutWrEn,
    input  logic [LUT_IDX_W-1:0] LutWrIdx,
    input  logic [PC_W-1:0]      LutWrData,
    output logic [PC_W-1:0]      PC,
    output logic                 ScReg,
    output logic                 Running,
    output logic                 Done,
    output logic [CNT_W-1:0]     BrCount
);

    localparam int unsigned LUT_N = 1 << LUT_IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc_q, pc_nx;
    logic            sc_q, sc_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic            lut_we;
    logic [PC_W-1:0] br_target;

    logic [PC_W-1:0] lut [LUT_N];

    assign br_target = lut[LutIdx];

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        sc_nx    = sc_q;
        cnt_nx   = cnt_q;
        lut_we   = 1'b0;
        case (state)
            IDLE: begin
                lut_we = LutWrEn;
                if (Start) begin
                    state_nx = RUN;
                    pc_nx    = '0;
                    sc_nx    = 1'b0;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                if (!StallIn) begin
                    if (ScWrEn) begin
                        sc_nx = ScIn;
                    end
                    // Halt wins over a taken branch; PC stays on the halt instruction
                    if (Halt) begin
                        state_nx = HALTED;
                    end else if (BranchEn && BR_FLAG) begin
                        pc_nx = br_target;
                        if (cnt_q != '1) begin
                            cnt_nx = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        pc_nx = pc_q + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if (Start) begin
                    state_nx = RUN;
                    pc_nx    = '0;
                    sc_nx    = 1'b0;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc_q  <= '0;
            sc_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            sc_q  <= sc_nx;
            cnt_q <= cnt_nx;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < LUT_N; i++) begin
                lut[LUT_IDX_W'(i)] <= '0;
            end
        end else if (lut_we) begin
            lut[LutWrIdx] <= LutWrData;
        end
    end

    assign PC      = pc_q;
    assign ScReg   = sc_q;
    assign BrCount = cnt_q;
    assign Running = (state == RUN);
    assign Done    = (state == HALTED);

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter and branch-resolution stage directly downstream of the combinational ALU. Each cycle it consumes the ALU's branch flag and shift/carry-out, selects the next instruction address (sequential, branch target, or hold), and registers the carry bit that feeds back to the ALU's shift/carry input. It also owns the program start/done handshake with the test harness and a small branch-target lookup table loaded before execution.

## Interface
- PC_W, 10, program counter width in bits
- LUT_IDX_W, 4, branch-target LUT index width (2^LUT_IDX_W entries of PC_W bits)
- CNT_W, 8, width of the taken-branch counter
- CLK  in  1  rising-edge clock, the single clock for the block
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin execution at address 0 (sampled in IDLE or HALTED)
- StallIn  in  1  freeze PC, carry and counter this cycle (instruction memory busy)
- BranchEn  in  1  current instruction is a branch
- BR_FLAG  in  1  ALU branch-taken flag
- LutIdx  in  LUT_IDX_W  branch target select from current instruction
- Halt  in  1  current instruction is halt
- ScIn  in  1  ALU shift/carry out
- ScWrEn  in  1  current instruction writes the carry register
- LutWrEn  in  1  write LUT entry (honoured only in IDLE)
- LutWrIdx  in  LUT_IDX_W  LUT write address
- LutWrData  in  PC_W  LUT write data
- PC  out  PC_W  current instruction address
- ScReg  out  1  registered carry, drives ALU shift/carry in
- Running  out  1  high in RUN state
- Done  out  1  high in HALTED state
- BrCount  out  CNT_W  saturating count of taken branches since last Start

## Operation
- States: IDLE, RUN, HALTED. Reset forces IDLE, PC=0, ScReg=0, BrCount=0, Done=0, Running=0, all LUT entries=0.
- IDLE: LutWrEn writes LUT[LutWrIdx]<=LutWrData. Start -> RUN, PC<=0, ScReg<=0, BrCount<=0. LUT write and Start in same cycle: both take effect.
- RUN, StallIn=1: PC, ScReg, BrCount, state all hold; Halt/BranchEn/ScWrEn ignored that cycle.
- RUN, StallIn=0, next-PC priority: Halt > taken branch > increment.
  - Halt=1: -> HALTED, PC holds (points at halt instruction).
  - BranchEn=1 and BR_FLAG=1: PC<=LUT[LutIdx]; BrCount<=BrCount+1, saturating at 2^CNT_W-1.
  - otherwise PC<=PC+1, wrapping from 2^PC_W-1 to 0.
  - BR_FLAG=1 with BranchEn=0: no effect.
  - ScWrEn=1: ScReg<=ScIn, independent of PC choice (also applied when Halt=1).
- HALTED: Done=1, all registers hold. Start -> RUN with PC<=0, ScReg<=0, BrCount<=0.
- LutWrEn outside IDLE is ignored; Start in RUN is ignored.
- Running and Done decoded from state register only (glitch-free, never both high).

## Timing
- All state updates on CLK rising edge; Reset acts immediately and asynchronously, release synchronous to next edge.
- PC is registered: decision inputs in cycle n select PC visible in cycle n+1. Single-cycle latency, no bubbles on taken branch.
- LUT read is combinational on LutIdx; LUT write visible to a read on the cycle after the write.
- Done rises the cycle after Halt is accepted; drops the cycle after Start is sampled in HALTED.
- Reset asserted mid-RUN: state returns to IDLE and LUT is cleared; program must be reloaded.

## Test plan
- Reset then Start, no branches, 5 cycles -> PC sequence 0,1,2,3,4,5; Running=1, Done=0, BrCount=0.
- In IDLE write LUT[3]=0x120, Start, at PC=2 drive BranchEn=1, BR_FLAG=1, LutIdx=3 -> next PC=0x120, BrCount=1; repeat with BR_FLAG=0 -> PC+1, BrCount unchanged.
- At PC=7 assert StallIn for 3 cycles with BranchEn=1, BR_FLAG=1, ScWrEn=1, ScIn=1 -> PC stays 7, ScReg stays 0, BrCount unchanged; on release PC=8.
- Halt and taken branch in same cycle at PC=9 -> PC stays 9, Done=1 next cycle; Start -> PC=0, Done=0, BrCount=0.
- PC at 0x3FF, no branch -> PC=0x000; 260 taken branches -> BrCount saturates at 255.
- Reset asserted in RUN at PC=0x55 -> PC=0, state IDLE, LUT[3] reads 0 afterwards; LutWrEn during RUN leaves LUT unchanged.
